// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of a shared single-cycle ALU.
// One operation is in flight at a time: IDLE (grant) -> EXEC (drive ALU) -> RESP (return result).
module alu_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic [2:0]  req0_funct3,
    input  logic        req0_shift_ctrl,
    input  logic        req0_sub_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [2:0]  req1_funct3,
    input  logic        req1_shift_ctrl,
    input  logic        req1_sub_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_funct3,
    output logic        alu_shift_ctrl,
    output logic        alu_sub_ctrl,
    input  logic [31:0] alu_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        last_grant_r;
    logic        owner_r;
    logic        winner_s;
    logic        accept_s;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [2:0]  funct3_r;
    logic        shift_r;
    logic        sub_r;
    logic [31:0] result_r;

    // Winner selection; on a tie round-robin favours the port not granted last.
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_s = PRIO_FIXED ? 1'b0 : ~last_grant_r;
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and handshake outputs; ready is masked while reset is asserted.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept_s   = 1'b1;
                    req0_ready = ~winner_s;
                    req1_ready = winner_s;
                    state_s    = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                state_s = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner_r;
                rsp1_valid = owner_r;
                if (owner_r ? rsp1_ready : rsp0_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant history, operand capture and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            op1_r        <= 32'h0000_0000;
            op2_r        <= 32'h0000_0000;
            funct3_r     <= 3'b000;
            shift_r      <= 1'b0;
            sub_r        <= 1'b0;
            result_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                last_grant_r <= winner_s;
                owner_r      <= winner_s;
                op1_r        <= winner_s ? req1_op1        : req0_op1;
                op2_r        <= winner_s ? req1_op2        : req0_op2;
                funct3_r     <= winner_s ? req1_funct3     : req0_funct3;
                shift_r      <= winner_s ? req1_shift_ctrl : req0_shift_ctrl;
                sub_r        <= winner_s ? req1_sub_ctrl   : req0_sub_ctrl;
            end else begin
                owner_r <= owner_r;
            end
            if (state_r == EXEC) begin
                result_r <= alu_out;
            end else begin
                result_r <= result_r;
            end
        end
    end

    // Datapath outputs come straight from registers so the ALU sees stable operands.
    always_comb begin
        alu_in1        = op1_r;
        alu_in2        = op2_r;
        alu_funct3     = funct3_r;
        alu_shift_ctrl = shift_r;
        alu_sub_ctrl   = sub_r;
        rsp0_data      = result_r;
        rsp1_data      = result_r;
        busy           = (state_r != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// each is served by a behavioural ALU and checked against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        req0_shift_ctrl, req0_sub_ctrl, req1_shift_ctrl, req1_sub_ctrl;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_data, rsp1_data, alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_funct3;
    logic        alu_shift_ctrl, alu_sub_ctrl;

    logic        fx_req0_ready, fx_req1_ready, fx_rsp0_valid, fx_rsp1_valid, fx_busy;
    logic [31:0] fx_rsp0_data, fx_rsp1_data, fx_alu_in1, fx_alu_in2, fx_alu_out;
    logic [2:0]  fx_alu_funct3;
    logic        fx_alu_shift_ctrl, fx_alu_sub_ctrl;

    int   checks = 0;
    int   failures = 0;
    logic model_last;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        sh;
        logic        sb;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    // RISC-V style integer ALU, standing in for the shared execute ALU.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f, input logic sh, input logic sb);
        case (f)
            3'd0:    return sb ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return sh ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_out    = alu_ref(alu_in1, alu_in2, alu_funct3, alu_shift_ctrl, alu_sub_ctrl);
    assign fx_alu_out = alu_ref(fx_alu_in1, fx_alu_in2, fx_alu_funct3, fx_alu_shift_ctrl, fx_alu_sub_ctrl);

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_funct3(req0_funct3), .req0_shift_ctrl(req0_shift_ctrl), .req0_sub_ctrl(req0_sub_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_funct3(req1_funct3), .req1_shift_ctrl(req1_shift_ctrl), .req1_sub_ctrl(req1_sub_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funct3(alu_funct3),
        .alu_shift_ctrl(alu_shift_ctrl), .alu_sub_ctrl(alu_sub_ctrl), .alu_out(alu_out), .busy(busy)
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_funct3(req0_funct3), .req0_shift_ctrl(req0_shift_ctrl), .req0_sub_ctrl(req0_sub_ctrl),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_funct3(req1_funct3), .req1_shift_ctrl(req1_shift_ctrl), .req1_sub_ctrl(req1_sub_ctrl),
        .rsp0_valid(fx_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fx_rsp0_data),
        .rsp1_valid(fx_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fx_rsp1_data),
        .alu_in1(fx_alu_in1), .alu_in2(fx_alu_in2), .alu_funct3(fx_alu_funct3),
        .alu_shift_ctrl(fx_alu_shift_ctrl), .alu_sub_ctrl(fx_alu_sub_ctrl), .alu_out(fx_alu_out),
        .busy(fx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_req1_ready", req1_ready, 32'd0);
        chk("rst_rsp0_valid", rsp0_valid, 32'd0);
        chk("rst_rsp1_valid", rsp1_valid, 32'd0);
        chk("rst_rsp0_data", rsp0_data, 32'd0);
        chk("rst_rsp1_data", rsp1_data, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_alu_funct3", alu_funct3, 32'd0);
        chk("rst_alu_shift", alu_shift_ctrl, 32'd0);
        chk("rst_alu_sub", alu_sub_ctrl, 32'd0);
        chk("rst_busy", busy, 32'd0);
    endtask

    task automatic garble();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_op1 = $urandom; req0_op2 = $urandom; req0_funct3 = 3'($urandom_range(0, 7));
        req1_op1 = $urandom; req1_op2 = $urandom; req1_funct3 = 3'($urandom_range(0, 7));
        req0_shift_ctrl = 1'($urandom_range(0, 1)); req0_sub_ctrl = 1'($urandom_range(0, 1));
        req1_shift_ctrl = 1'($urandom_range(0, 1)); req1_sub_ctrl = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    // One full transaction starting in IDLE just after a rising edge; ends the same way.
    task automatic transact(input logic v0, input logic v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] f0,
                            input logic sh0, input logic sb0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] f1,
                            input logic sh1, input logic sb1,
                            input int hold, input bit keep, input bit use_ovr, input logic [31:0] exp_ovr);
        logic w, e0, e1;
        logic [31:0] ea, eb, exp;
        logic [2:0] ef;
        logic esh, esb;
        w   = (v0 && v1) ? ~model_last : v1;
        e0  = ~w;
        e1  = w;
        ea  = w ? a1 : a0;  eb  = w ? b1 : b0;  ef = w ? f1 : f0;
        esh = w ? sh1 : sh0; esb = w ? sb1 : sb0;
        exp = use_ovr ? exp_ovr : alu_ref(ea, eb, ef, esh, esb);
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_funct3 = f0;
        req0_shift_ctrl = sh0; req0_sub_ctrl = sb0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_funct3 = f1;
        req1_shift_ctrl = sh1; req1_sub_ctrl = sb1;
        rsp0_ready = w ? 1'b1 : (hold == 0);
        rsp1_ready = w ? (hold == 0) : 1'b1;
        @(negedge clk);
        chk("grant_ready0", req0_ready, e0);
        chk("grant_ready1", req1_ready, e1);
        chk("idle_busy", busy, 32'd0);
        @(posedge clk); #1;
        model_last = w;
        if (!keep) garble();
        chk("exec_busy", busy, 32'd1);
        chk("exec_rsp0_valid", rsp0_valid, 32'd0);
        chk("exec_rsp1_valid", rsp1_valid, 32'd0);
        chk("exec_ready", {req0_ready, req1_ready}, 32'd0);
        chk("exec_alu_in1", alu_in1, ea);
        chk("exec_alu_in2", alu_in2, eb);
        chk("exec_alu_funct3", alu_funct3, ef);
        chk("exec_alu_ctrl", {alu_shift_ctrl, alu_sub_ctrl}, {esh, esb});
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid0", rsp0_valid, e0);
            chk("resp_valid1", rsp1_valid, e1);
            chk("resp_data", w ? rsp1_data : rsp0_data, exp);
            chk("resp_ready", {req0_ready, req1_ready}, 32'd0);
            chk("resp_busy", busy, 32'd1);
            if (i == hold) begin
                if (w) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            end
            if (!keep) garble();
            @(posedge clk); #1;
        end
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk("done_busy", busy, 32'd0);
        chk("done_rsp_valid", {rsp0_valid, rsp1_valid}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 3'd0, 1'b0, 1'b1, 0, 32'h0000_0002};
        vecs[1] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 3'd0, 1'b0, 1'b0, 1, 32'h0000_0008};
        vecs[2] = '{1'b1, 32'h0000_0001, 32'h0000_0004, 3'd1, 1'b0, 1'b0, 0, 32'h0000_0010};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0004, 3'd5, 1'b1, 1'b0, 2, 32'hF800_0000};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0004, 3'd5, 1'b0, 1'b0, 0, 32'h0800_0000};
        vecs[5] = '{1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'd4, 1'b0, 1'b0, 5, 32'hF0F0_0F0F};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 1'b0, 0, 32'h0000_0001};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0, 1'b0, 0, 32'h0000_0000};
        vecs[8] = '{1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 1'b0, 1'b0, 1, 32'hFFF0_FFF0};
        vecs[9] = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd7, 1'b0, 1'b0, 0, 32'h00F0_00F0};

        rst_n = 1'b0;
        model_last = 1'b1;
        req0_valid = 1'b1; req0_op1 = 32'h5; req0_op2 = 32'h3; req0_funct3 = 3'd0;
        req0_shift_ctrl = 1'b0; req0_sub_ctrl = 1'b1;
        req1_valid = 1'b0; req1_op1 = 32'h0; req1_op2 = 32'h0; req1_funct3 = 3'd0;
        req1_shift_ctrl = 1'b0; req1_sub_ctrl = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset with a pending request, then first IDLE cycle grants it.
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready0", req0_ready, 32'd1);
        chk("post_reset_ready1", req1_ready, 32'd0);

        // Directed table, covering every funct3 plus backpressure.
        for (int i = 0; i < 10; i++) begin
            transact(~vecs[i].port, vecs[i].port,
                     vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].sh, vecs[i].sb,
                     vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].sh, vecs[i].sb,
                     vecs[i].hold, 1'b0, 1'b1, vecs[i].exp);
        end

        // Reset in EXEC after a port-0 grant: op is dropped and the tie pointer is restored.
        transact(1'b1, 1'b0, 32'h7, 32'h1, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0,
                 0, 1'b0, 1'b0, 32'h0);
        req0_valid = 1'b1; req0_op1 = 32'h1234_5678; req0_op2 = 32'h1; req0_funct3 = 3'd0;
        @(posedge clk); #1;
        chk("midrst_exec_busy", busy, 32'd1);
        rst_n = 1'b0;
        #1;
        req0_valid = 1'b0;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {rsp0_valid, rsp1_valid, busy}, 32'd0);
        end
        @(posedge clk); #1;
        transact(1'b1, 1'b1, 32'h9, 32'h4, 3'd0, 1'b0, 1'b1, 32'h1, 32'h1, 3'd4, 1'b0, 1'b0,
                 0, 1'b0, 1'b1, 32'h0000_0005);

        // Round-robin with both ports valid continuously: grants 0,1,0,1.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            transact(1'b1, 1'b1, 32'h1, 32'h4, 3'd1, 1'b0, 1'b0,
                     32'h8000_0000, 32'h4, 3'd5, 1'b1, 1'b0,
                     0, 1'b1, 1'b1, (k % 2 == 0) ? 32'h0000_0010 : 32'hF800_0000);
        end

        // Fixed priority instance: port 0 wins every time.
        do_reset();
        grants = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("fx_ready1_low", fx_req1_ready, 32'd0);
            chk("fx_rsp1_low", fx_rsp1_valid, 32'd0);
            if (fx_req0_ready) grants++;
            if (fx_rsp0_valid) chk("fx_rsp0_data", fx_rsp0_data, 32'h0000_0010);
        end
        chk("fx_grant_count", 32'(grants), 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomised transactions against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            logic rv0, rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("rand_idle", {req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid}, 32'd0);
                @(posedge clk); #1;
            end else begin
                transact(rv0, rv1, $urandom, $urandom, 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom, $urandom, 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3), 1'b0, 1'b0, 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle execute ALU between two requesters (port 0: integer execute path; port 1: auxiliary path such as address/CSR computation) using valid/ready handshakes. Accepts one operation at a time, drives the shared ALU from registered operands, captures the result and returns it on the owner's response channel. Sits between the requesters and the ALU instance in the execute stage.

## Interface
- PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins ties
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  32  operands
- req0_funct3 / req1_funct3  in  3  ALU operation select
- req0_shift_ctrl / req1_shift_ctrl  in  1  arithmetic (1) vs logical (0) right shift
- req0_sub_ctrl / req1_sub_ctrl  in  1  subtract (1) vs add (0) when funct3 = 000
- rsp0_valid / rsp1_valid  out  1  result available for port 0 / 1
- rsp0_ready / rsp1_ready  in  1  port consumes result
- rsp0_data / rsp1_data  out  32  result
- alu_in1, alu_in2  out  32  to shared ALU operands
- alu_funct3  out  3  to shared ALU
- alu_shift_ctrl, alu_sub_ctrl  out  1  to shared ALU
- alu_out  in  32  shared ALU result (combinational in ALU)
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: winner selection over req*_valid; winner's req*_ready = 1 (combinational from state and valids), loser's = 0. On the edge: capture winner's op1/op2/funct3/shift_ctrl/sub_ctrl into operand registers, owner register = winner index, go EXEC. No valid: stay IDLE, both ready = 0.
- Selection: single valid wins. Both valid: PRIO_FIXED=1 -> port 0; PRIO_FIXED=0 -> port not equal to last_grant. last_grant updates to winner on acceptance; reset value 1 (port 0 wins first tie).
- EXEC: alu_* outputs are the operand registers (held since acceptance). On the edge: result register <= alu_out, go RESP.
- RESP: rsp[owner]_valid = 1, rsp[owner]_data = result register; other port's rsp_valid = 0. Both req ready = 0. When rsp[owner]_ready = 1: go IDLE. rsp_ready low holds RESP indefinitely with data stable.
- rsp*_data for the non-owner port: result register value, not qualified (ignored).
- Requester may drop req_valid before ready without penalty; no request is latched unless ready was high at the edge.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Reset (rst_n low, any state, including mid-EXEC or RESP): state IDLE, last_grant 1, owner 0, operand registers 0, result register 0; outputs req*_ready 0, rsp*_valid 0, rsp*_data 0, alu_in1/alu_in2 0, alu_funct3 0, alu_shift_ctrl 0, alu_sub_ctrl 0, busy 0. In-flight op discarded, no response produced.
- Request accepted at edge N (valid & ready) -> alu_* reflect it from N; result captured at N+1; rsp_valid high from after N+1 until the edge where rsp_ready is sampled high.
- Minimum latency request-accept to response-valid: 2 cycles. Max throughput: one op per 3 cycles (rsp_ready held high).
- Return to IDLE and new acceptance never in the same cycle as a response handshake.
- rsp_ready high while not in RESP: no effect.

## Test plan
- Reset: assert rst_n = 0 with req0_valid = 1 -> all outputs 0, busy 0; release -> req0_ready = 1 in first IDLE cycle.
- Single op: port 0 op1 = 0x00000005, op2 = 0x00000003, funct3 = 000, sub_ctrl = 1, rsp0_ready = 1 -> rsp0_valid two cycles after acceptance, rsp0_data = 0x00000002, rsp1_valid stays 0.
- Round-robin: both valid continuously, four ops (port 0 SLL 0x1<<4, port 1 SRA 0x80000000 by 4, …) -> grant order 0,1,0,1; results 0x00000010 and 0xF8000000 to the correct ports.
- Fixed priority (PRIO_FIXED = 1): both valid continuously -> port 0 granted every time, req1_ready never high.
- Backpressure: port 1 XOR 0xFFFF0000 ^ 0x0F0F0F0F, rsp1_ready low for 5 cycles -> rsp1_valid and rsp1_data = 0xF0F00F0F held stable, both req_ready 0, busy 1; handshake completes on rsp1_ready.
- Reset mid-operation: pull rst_n low in EXEC -> no rsp_valid ever for that op; after release, next request processes normally with last_grant back to reset value.
